// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Owner states, the fixed fetch byte mask and the watchdog counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    localparam logic [3:0] FETCH_MASK = 4'b1111;

    // Wide enough to hold TimeoutCycles-1, the last count before abort.
    function automatic int timeout_w(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Watchdog for one memory transaction: counts unanswered busy cycles and
// flags the cycle on which the transaction must be abandoned.
module mem_timeout_counter
    import mem_arb_pkg::*;
#(
    parameter int TimeoutCycles = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CntW = timeout_w(TimeoutCycles);
    localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Saturates at the last count so a stalled owner cannot wrap it.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, alternating owners under contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [DataWidth-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_valid,
    output logic [DataWidth-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_mask,
    input  logic [DataWidth-1:0] d_addr,
    input  logic [DataWidth-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_valid,
    output logic [DataWidth-1:0] d_rdata,
    output logic                 m_req,
    output logic                 m_we,
    output logic [3:0]           m_mask,
    output logic [DataWidth-1:0] m_addr,
    output logic [DataWidth-1:0] m_wdata,
    input  logic                 m_valid,
    input  logic [DataWidth-1:0] m_rdata,
    output logic                 busy,
    output logic                 err
);

    // Handshake: a requester holds req (and its payload) until it sees its
    // gnt pulse; the owner later gets exactly one valid pulse per grant.
    arb_state_e           state_q, state_d;
    logic                 last_data_q, last_data_d;
    logic                 m_req_q, m_req_d;
    logic                 m_we_q, m_we_d;
    logic [3:0]           m_mask_q, m_mask_d;
    logic [DataWidth-1:0] m_addr_q, m_addr_d;
    logic [DataWidth-1:0] m_wdata_q, m_wdata_d;

    logic in_idle;
    logic grant_if;
    logic grant_d;
    logic expired;
    logic timeout;
    logic done;

    assign in_idle  = (state_q == IDLE);
    assign grant_if = rst && in_idle && if_req && (!d_req || last_data_q);
    assign grant_d  = rst && in_idle && d_req && (!if_req || !last_data_q);
    assign timeout  = !in_idle && !m_valid && expired;
    assign done     = !in_idle && (m_valid || timeout);

    mem_timeout_counter #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (grant_if || grant_d),
        .enable (!in_idle && !m_valid),
        .expired(expired)
    );

    always_comb begin
        state_d     = state_q;
        last_data_d = last_data_q;
        m_req_d     = m_req_q;
        m_we_d      = m_we_q;
        m_mask_d    = m_mask_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = BUSY_D;
                    last_data_d = 1'b1;
                    m_req_d     = 1'b1;
                    m_we_d      = d_we;
                    m_mask_d    = d_mask;
                    m_addr_d    = d_addr;
                    m_wdata_d   = d_wdata;
                end else if (grant_if) begin
                    state_d     = BUSY_IF;
                    last_data_d = 1'b0;
                    m_req_d     = 1'b1;
                    m_we_d      = 1'b0;
                    m_mask_d    = FETCH_MASK;
                    m_addr_d    = if_addr;
                    m_wdata_d   = '0;
                end
            end
            default: begin
                if (done) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_data_q <= 1'b0;
            m_req_q     <= 1'b0;
            m_we_q      <= 1'b0;
            m_mask_q    <= 4'b0000;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_data_q <= last_data_d;
            m_req_q     <= m_req_d;
            m_we_q      <= m_we_d;
            m_mask_q    <= m_mask_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
        end
    end

    assign if_gnt   = grant_if;
    assign d_gnt    = grant_d;
    assign if_valid = rst && (state_q == BUSY_IF) && done;
    assign d_valid  = rst && (state_q == BUSY_D) && done;
    // An aborted transaction returns zero data; stores never return data.
    assign if_rdata = (rst && (state_q == BUSY_IF) && m_valid) ? m_rdata : '0;
    assign d_rdata  = (rst && (state_q == BUSY_D) && m_valid && !m_we_q) ? m_rdata : '0;
    assign err      = rst && timeout;
    assign busy     = !in_idle;

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_mask  = m_mask_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations,
// using a short watchdog so the abort path is reachable.
module tb_mem_port_arbiter;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [DW-1:0] if_addr;
    logic          if_gnt;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_mask;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_valid;
    logic [DW-1:0] d_rdata;
    logic          m_req;
    logic          m_we;
    logic [3:0]    m_mask;
    logic [DW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_valid;
    logic [DW-1:0] m_rdata;
    logic          busy;
    logic          err;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(
        .DataWidth    (DW),
        .TimeoutCycles(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_gnt  (if_gnt),
        .if_valid(if_valid),
        .if_rdata(if_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_mask  (d_mask),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_valid (d_valid),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_mask  (m_mask),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_valid (m_valid),
        .m_rdata (m_rdata),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_mask  = 4'b0000;
        d_addr  = '0;
        d_wdata = '0;
        m_valid = 1'b0;
        m_rdata = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        idle_inputs();
        if_req = 1'b1;
        d_req  = 1'b1;
        tick();
        sample();
        check_eq("rst_if_gnt", if_gnt, 0);
        check_eq("rst_d_gnt", d_gnt, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_m_req", m_req, 0);
        check_eq("rst_m_mask", m_mask, 0);
        check_eq("rst_err", err, 0);
        tick();
        idle_inputs();
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        apply_reset();

        // Fetch only, answered on the third busy cycle.
        if_req = 1'b1; if_addr = 32'h100;
        sample();
        check_eq("f_gnt", if_gnt, 1);
        check_eq("f_busy0", busy, 0);
        tick();
        if_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin m_valid = 1'b1; m_rdata = 32'h13; end
            sample();
            check_eq("f_m_req", m_req, 1);
            check_eq("f_m_addr", m_addr, 32'h100);
            check_eq("f_m_mask", m_mask, 4'b1111);
            check_eq("f_m_wdata", m_wdata, 0);
            check_eq("f_if_valid", if_valid, (c == 3) ? 1 : 0);
            tick();
        end
        m_valid = 1'b0;
        sample();
        check_eq("f_rdata_gone", if_valid, 0);
        check_eq("f_busy4", busy, 0);
        check_eq("f_m_req4", m_req, 0);
        tick();

        // Contention straight out of reset: data, fetch, data.
        apply_reset();
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_mask = 4'b1111; d_addr = 32'h2000;
        sample();
        check_eq("c0_d_gnt", d_gnt, 1);
        check_eq("c0_if_gnt", if_gnt, 0);
        tick();
        m_valid = 1'b1; m_rdata = 32'hCAFE0001;
        sample();
        check_eq("c1_m_addr", m_addr, 32'h2000);
        check_eq("c1_no_gnt", {if_gnt, d_gnt}, 0);
        check_eq("c1_d_valid", d_valid, 1);
        check_eq("c1_d_rdata", d_rdata, 32'hCAFE0001);
        check_eq("c1_if_valid", if_valid, 0);
        tick();
        m_valid = 1'b0;
        sample();
        check_eq("c2_if_gnt", if_gnt, 1);
        check_eq("c2_d_gnt", d_gnt, 0);
        tick();
        m_valid = 1'b1; m_rdata = 32'h13;
        sample();
        check_eq("c3_m_addr", m_addr, 32'h200);
        check_eq("c3_if_valid", if_valid, 1);
        check_eq("c3_if_rdata", if_rdata, 32'h13);
        tick();
        m_valid = 1'b0;
        sample();
        check_eq("c4_d_gnt", d_gnt, 1);
        check_eq("c4_if_gnt", if_gnt, 0);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        m_valid = 1'b1; m_rdata = 32'h1;
        sample();
        check_eq("c5_d_valid", d_valid, 1);
        tick();
        idle_inputs();
        tick();

        // Store: returned read data must not leak to the requester.
        d_req = 1'b1; d_we = 1'b1; d_mask = 4'b0011;
        d_addr = 32'h3000; d_wdata = 32'hDEADBEEF;
        sample();
        check_eq("s_d_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0;
        m_valid = 1'b1; m_rdata = 32'hFFFFFFFF;
        sample();
        check_eq("s_m_we", m_we, 1);
        check_eq("s_m_mask", m_mask, 4'b0011);
        check_eq("s_m_wdata", m_wdata, 32'hDEADBEEF);
        check_eq("s_m_addr", m_addr, 32'h3000);
        check_eq("s_d_valid", d_valid, 1);
        check_eq("s_d_rdata", d_rdata, 0);
        tick();
        idle_inputs();
        sample();
        check_eq("s_busy", busy, 0);
        tick();

        // Watchdog abort after four unanswered busy cycles.
        if_req = 1'b1; if_addr = 32'h400;
        sample();
        check_eq("t_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            sample();
            check_eq("t_err", err, (c == 4) ? 1 : 0);
            check_eq("t_if_valid", if_valid, (c == 4) ? 1 : 0);
            check_eq("t_if_rdata", if_rdata, 0);
            check_eq("t_busy", busy, 1);
            tick();
        end
        sample();
        check_eq("t5_m_req", m_req, 0);
        check_eq("t5_err", err, 0);
        tick();
        m_valid = 1'b1; m_rdata = 32'h55;
        sample();
        check_eq("t6_stray_if", if_valid, 0);
        check_eq("t6_stray_d", d_valid, 0);
        check_eq("t6_busy", busy, 0);
        tick();
        m_valid = 1'b0;

        // Response arriving on the abort cycle wins over the timeout.
        if_req = 1'b1; if_addr = 32'h500;
        sample();
        check_eq("r_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        tick(); tick(); tick();
        m_valid = 1'b1; m_rdata = 32'h600D;
        sample();
        check_eq("r_err", err, 0);
        check_eq("r_if_valid", if_valid, 1);
        check_eq("r_if_rdata", if_rdata, 32'h600D);
        tick();
        m_valid = 1'b0;

        // Reset during a load discards it and forgets the last owner.
        d_req = 1'b1; d_we = 1'b0; d_mask = 4'b1111; d_addr = 32'h7000;
        sample();
        check_eq("m_d_gnt", d_gnt, 1);
        tick();
        d_req = 1'b0;
        tick();
        rst = 1'b0; m_valid = 1'b1; m_rdata = 32'h77;
        sample();
        check_eq("m_rst_d_valid", d_valid, 0);
        check_eq("m_rst_d_rdata", d_rdata, 0);
        check_eq("m_rst_err", err, 0);
        tick();
        rst = 1'b1; m_valid = 1'b0;
        if_req = 1'b1; if_addr = 32'h800;
        d_req = 1'b1; d_addr = 32'h9000;
        sample();
        check_eq("m_busy", busy, 0);
        check_eq("m_m_req", m_req, 0);
        check_eq("m_d_valid", d_valid, 0);
        check_eq("m_tie_d_gnt", d_gnt, 1);
        check_eq("m_tie_if_gnt", if_gnt, 0);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        m_valid = 1'b1; m_rdata = 32'h99;
        sample();
        check_eq("m_post_addr", m_addr, 32'h9000);
        check_eq("m_post_valid", d_valid, 1);
        check_eq("m_post_rdata", d_rdata, 32'h99);
        tick();
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between the instruction-fetch unit and the load/store unit.
- Accepts one request from each side, grants one at a time, and holds the memory request stable until the memory returns valid.
- Routes the response back to the owner and alternates owners under contention.
- A watchdog aborts transactions the memory never answers, so the pipeline cannot hang.

Parameters:
- DataWidth, 32, width of address, write data and read data.
- TimeoutCycles, 64, number of cycles in a busy state without m_valid before abort (minimum 2).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  DataWidth  fetch address
- if_gnt  out  1  fetch request accepted, combinational, one-cycle pulse
- if_valid  out  1  fetch data valid, one-cycle pulse
- if_rdata  out  DataWidth  fetched instruction
- d_req  in  1  load/store request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_mask  in  4  byte enables
- d_addr  in  DataWidth  data address
- d_wdata  in  DataWidth  store data
- d_gnt  out  1  data request accepted, combinational pulse
- d_valid  out  1  load data valid / store acknowledge, one-cycle pulse
- d_rdata  out  DataWidth  load data
- m_req  out  1  memory request, registered
- m_we  out  1  memory write enable, registered
- m_mask  out  4  memory byte enables, registered; 4'b1111 for fetch
- m_addr  out  DataWidth  memory address, registered
- m_wdata  out  DataWidth  memory write data, registered; 0 for fetch
- m_valid  in  1  memory response valid
- m_rdata  in  DataWidth  memory read data
- busy  out  1  state is not IDLE
- err  out  1  timeout abort, one-cycle pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-low; it is sampled on the rising edge of clk and asserted when low.
- Reset values: state IDLE; m_req, m_we, m_addr, m_wdata, err, busy and last_data all 0; m_mask 4'b0000. if_gnt, d_gnt, if_valid and d_valid are forced 0 while rst is low. if_rdata and d_rdata are 0. Reset in the middle of a transaction discards it without issuing any valid pulse.
- States:
  - IDLE: no transaction in progress.
  - BUSY_IF: fetch owns the memory port.
  - BUSY_D: load/store owns the memory port.
- IDLE arbitration:
  - Only d_req set: d_gnt = 1.
  - Only if_req set: if_gnt = 1.
  - Both set: if last_data = 1, fetch wins; otherwise data wins.
  - On the grant edge: capture the winner's request into the m_* registers, set m_req = 1, set last_data to the winner's kind, clear the timeout counter, and move to the matching BUSY state.
- BUSY states:
  - m_* registers are held constant and no grants are issued.
  - When m_valid = 1:
    - Fetch owner: if_valid = 1 and if_rdata = m_rdata, combinational in the same cycle.
    - Data owner: d_valid = 1; d_rdata = m_rdata for a load, 0 for a store.
    - Next edge: m_req cleared, state returns to IDLE.
- Latency:
  - Request seen in IDLE at cycle N gives m_req = 1 at N+1.
  - The earliest valid pulse is at N+1.
  - The next grant is possible at N+2; IDLE always lasts at least one cycle.
- Timeout:
  - The counter increments each BUSY cycle with m_valid = 0.
  - On the cycle where the counter equals TimeoutCycles-1 and m_valid = 0: err = 1, the owner's valid = 1, the owner's rdata = 0. Next state is IDLE with m_req = 0.
  - If m_valid and the timeout occur in the same cycle, m_valid wins and err stays 0.
- m_valid in IDLE is ignored; a late response from an aborted transaction is dropped.
- Requests deasserted before their grant are allowed and produce no transaction.

Decomposition:
- Shared package mem_arb_pkg holds:
  - arb_state_e enum (IDLE, BUSY_IF, BUSY_D).
  - FETCH_MASK constant = 4'b1111.
  - TIMEOUT_W localparam function computing $clog2(TimeoutCycles).
- One sub-module: mem_timeout_counter, with inputs clear and enable, output expired. It is built from a counter sized by TimeoutCycles.

Test Plan:
- Fetch only: if_req with if_addr = 0x100 at cycle 0, m_valid = 1 with m_rdata = 0x00000013 at cycle 3. Expected: if_gnt at cycle 0; m_req = 1 with m_addr = 0x100 and m_mask = 1111 for cycles 1 to 3; if_valid with if_rdata = 0x13 at cycle 3; busy = 0 at cycle 4.
- Contention after reset: if_req and d_req (load, d_addr = 0x2000) both at cycle 0. Expected: d_gnt at cycle 0. After d_valid, with both requests still held, if_gnt wins the next IDLE, then data wins the IDLE after that (strict alternation).
- Store: d_we = 1, d_mask = 0011, d_wdata = 0xDEADBEEF. Expected: m_we = 1, m_mask = 0011, m_wdata = 0xDEADBEEF; d_valid with d_rdata = 0 when m_valid = 1 even though m_rdata = 0xFFFFFFFF.
- Timeout, TimeoutCycles = 4: fetch granted at cycle 0, m_valid never asserted. Expected: err = 1 and if_valid = 1 with if_rdata = 0 at cycle 4; m_req = 0 at cycle 5; a stray m_valid at cycle 6 produces no valid pulse.
- Reset in the middle of a transaction: rst low at cycle 2 of BUSY_D. Expected: next cycle state IDLE, m_req = 0, no d_valid pulse; a request at the first post-reset cycle is granted with last_data = 0, so data wins a tie.
